// File: rtl/puf_pkg.sv
// puf_pkg -- shared definitions for the PUF response collector.
//   PUF_N          : default sample width (matches the LFSR output width)
//   PUF_MISR_POLY  : default signature-register feedback polynomial
//   puf_state_e    : one-hot capture FSM encoding
//   sat_add32      : 32-bit saturating add used by the statistics counters
package puf_pkg;

   localparam int          PUF_N         = 32;
   localparam logic [31:0] PUF_MISR_POLY = 32'h04C11DB7;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'b0001,
      ST_ARMED   = 4'b0010,
      ST_CAPTURE = 4'b0100,
      ST_DONE    = 4'b1000
   } puf_state_e;

   // Clamp at all-ones instead of wrapping.
   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

endpackage

// File: rtl/puf_resp_collect_if.sv
// puf_resp_collect_if -- sample input stream and buffered-sample output stream.
//   in_valid/in_data          : LFSR sample stream into the collector
//   out_valid/out_data/out_ready : oldest buffered sample, popped on valid & ready
//   master : producer/consumer side (drives samples, accepts output)
//   slave  : collector side
interface puf_resp_collect_if #(
   parameter int N = 32
);
   logic         in_valid;
   logic [N-1:0] in_data;
   logic         out_valid;
   logic [N-1:0] out_data;
   logic         out_ready;

   modport master (output in_valid, in_data, out_ready, input out_valid, out_data);
   modport slave  (input in_valid, in_data, out_ready, output out_valid, out_data);
endinterface

// File: rtl/puf_resp_fifo.sv
// puf_resp_fifo -- registered sample buffer, no fall-through.
//   clk, rst    : clock, synchronous active-high reset
//   flush       : empties the buffer; beats push and pop in the same cycle
//   push/wr_data: write request (accepted when not full, or full with a pop)
//   pop         : read request (ignored when empty)
//   rd_data     : oldest entry, zero while empty
//   full/empty  : derived from the extra-MSB pointer comparison
module puf_resp_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] wr_data,
   input  logic         pop,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic         do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   // Gate the read port so an empty buffer never shows stale entries.
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      do_pop   = pop && !empty && !flush;
      do_push  = push && (!full || do_pop) && !flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (!rst && do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/puf_resp_collect.sv
// puf_resp_collect -- captures a burst of PUF/LFSR samples after arming,
// compacting them into a MISR signature, counting samples and ones, and
// buffering the raw samples for a downstream reader.
//   up_clk, up_rst : clock, synchronous active-high reset
//   cfg_arm        : one-cycle pulse, clears all state and arms capture
//   cfg_seed       : MISR start value, loaded on cfg_arm
//   bus            : sample input / buffered-sample output streams
//   sig            : MISR signature
//   ones_cnt       : saturating popcount total of captured samples
//   sample_cnt     : saturating count of captured samples
//   busy/done      : armed-or-capturing / burst finished
//   overflow       : sticky, a captured sample found the buffer full
module puf_resp_collect
   import puf_pkg::*;
#(
   parameter int           N          = PUF_N,
   parameter int           FIFO_DEPTH = 16,
   parameter logic [N-1:0] MISR_POLY  = N'(PUF_MISR_POLY)
) (
   input  logic            up_clk,
   input  logic            up_rst,
   input  logic            cfg_arm,
   input  logic [N-1:0]    cfg_seed,
   puf_resp_collect_if.slave bus,
   output logic [N-1:0]    sig,
   output logic [31:0]     ones_cnt,
   output logic [31:0]     sample_cnt,
   output logic            busy,
   output logic            done,
   output logic            overflow
);
   puf_state_e   state_q, state_d;
   logic [N-1:0] sig_q, sig_d;
   logic [31:0]  ones_q, ones_d;
   logic [31:0]  cnt_q, cnt_d;
   logic         ovf_q, ovf_d;
   logic         capture, push, pop, flush;
   logic         fifo_full, fifo_empty;

   function automatic logic [31:0] popcnt(input logic [N-1:0] v);
      logic [31:0] c;
      c = '0;
      for (int i = 0; i < N; i++) c = c + 32'(v[i]);
      return c;
   endfunction

   // The arm cycle flushes the buffer, so no pop may be credited then.
   assign pop = bus.out_valid && bus.out_ready && !cfg_arm;

   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      ones_d  = ones_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      flush   = 1'b0;
      push    = 1'b0;
      capture = 1'b0;
      if (cfg_arm) begin
         // Arm wins over a coincident sample, which is simply dropped.
         state_d = ST_ARMED;
         sig_d   = cfg_seed;
         ones_d  = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
         flush   = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE:    state_d = ST_IDLE;
            ST_ARMED:   if (bus.in_valid)  state_d = ST_CAPTURE;
            ST_CAPTURE: if (!bus.in_valid) state_d = ST_DONE;
            ST_DONE:    state_d = ST_DONE;
            default:    state_d = ST_IDLE;
         endcase
         capture = bus.in_valid && (state_q == ST_ARMED || state_q == ST_CAPTURE);
         if (capture) begin
            sig_d  = {sig_q[N-2:0], 1'b0} ^ (sig_q[N-1] ? MISR_POLY : '0) ^ bus.in_data;
            ones_d = sat_add32(ones_q, popcnt(bus.in_data));
            cnt_d  = sat_add32(cnt_q, 32'd1);
            // A full buffer still takes the sample if a pop frees a slot this cycle.
            if (!fifo_full || pop) push  = 1'b1;
            else                   ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge up_clk) begin
      if (up_rst) begin
         state_q <= ST_IDLE;
         sig_q   <= '0;
         ones_q  <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         ones_q  <= ones_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   puf_resp_fifo #(
      .W     (N),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (up_clk),
      .rst     (up_rst),
      .flush   (flush),
      .push    (push),
      .wr_data (bus.in_data),
      .pop     (pop),
      .rd_data (bus.out_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign bus.out_valid = !fifo_empty;
   assign sig           = sig_q;
   assign ones_cnt      = ones_q;
   assign sample_cnt    = cnt_q;
   assign overflow      = ovf_q;
   assign busy          = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
   assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_puf_resp_collect.sv
// tb_puf_resp_collect -- randomized and directed stimulus against a queue-based
// reference model; a negedge monitor compares every presented output.
module tb_puf_resp_collect;
   localparam int          N     = 32;
   localparam int          DEPTH = 16;
   localparam logic [31:0] POLY  = 32'h04C11DB7;

   localparam int M_IDLE = 0, M_ARMED = 1, M_CAPT = 2, M_DONE = 3;

   logic        up_clk = 1'b0;
   logic        up_rst = 1'b0;
   logic        cfg_arm = 1'b0;
   logic [31:0] cfg_seed = '0;
   logic [31:0] sig, ones_cnt, sample_cnt;
   logic        busy, done, overflow;

   puf_resp_collect_if #(.N(N)) bus_if ();

   puf_resp_collect #(.N(N), .FIFO_DEPTH(DEPTH), .MISR_POLY(POLY)) dut (
      .up_clk     (up_clk),
      .up_rst     (up_rst),
      .cfg_arm    (cfg_arm),
      .cfg_seed   (cfg_seed),
      .bus        (bus_if),
      .sig        (sig),
      .ones_cnt   (ones_cnt),
      .sample_cnt (sample_cnt),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow)
   );

   always #5 up_clk = ~up_clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_sig = '0, m_ones = '0, m_cnt = '0;
   bit          m_ovf = 0;
   int          m_mode = M_IDLE;
   logic [31:0] m_q[$];
   bit          mon_en = 0;

   always @(posedge up_clk) begin
      bit     cap, pp;
      int     sz;
      longint tot;
      if (up_rst) begin
         m_mode = M_IDLE; m_sig = '0; m_ones = '0; m_cnt = '0; m_ovf = 0;
         m_q.delete();
      end else if (cfg_arm) begin
         m_mode = M_ARMED; m_sig = cfg_seed; m_ones = '0; m_cnt = '0; m_ovf = 0;
         m_q.delete();
      end else begin
         sz  = m_q.size();
         pp  = (sz != 0) && bus_if.out_ready;
         cap = bus_if.in_valid && (m_mode == M_ARMED || m_mode == M_CAPT);
         if (pp) void'(m_q.pop_front());
         if (cap) begin
            m_sig = (m_sig << 1) ^ (m_sig[31] ? POLY : 32'h0) ^ bus_if.in_data;
            tot   = longint'(m_ones) + $countones(bus_if.in_data);
            m_ones = (tot > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : tot[31:0];
            m_cnt  = (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
            if (sz < DEPTH || pp) m_q.push_back(bus_if.in_data);
            else m_ovf = 1;
         end
         if (m_mode == M_ARMED && bus_if.in_valid)      m_mode = M_CAPT;
         else if (m_mode == M_CAPT && !bus_if.in_valid) m_mode = M_DONE;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge up_clk) begin
      if (mon_en) begin
         chk("out_valid", 32'(bus_if.out_valid), 32'(m_q.size() != 0));
         if (bus_if.out_valid && m_q.size() != 0) chk("out_data", bus_if.out_data, m_q[0]);
         chk("sig", sig, m_sig);
         chk("ones_cnt", ones_cnt, m_ones);
         chk("sample_cnt", sample_cnt, m_cnt);
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("busy", 32'(busy), 32'(m_mode == M_ARMED || m_mode == M_CAPT));
         chk("done", 32'(done), 32'(m_mode == M_DONE));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge up_clk);
      #2;
   endtask

   task automatic arm(input logic [31:0] s);
      cfg_seed = s; cfg_arm = 1'b1;
      step();
      cfg_arm = 1'b0;
   endtask

   task automatic sample(input logic [31:0] d);
      bus_if.in_valid = 1'b1; bus_if.in_data = d;
      step();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_sig"}, sig, 32'h0);
      chk({tag, "_ones"}, ones_cnt, 32'h0);
      chk({tag, "_cnt"}, sample_cnt, 32'h0);
      chk({tag, "_ovalid"}, 32'(bus_if.out_valid), 32'h0);
      chk({tag, "_odata"}, bus_if.out_data, 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_done"}, 32'(done), 32'h0);
      chk({tag, "_ovf"}, 32'(overflow), 32'h0);
   endtask

   logic [31:0] data[20];
   logic [31:0] d21, s2;

   initial begin
      bus_if.in_valid = 1'b0; bus_if.in_data = '0; bus_if.out_ready = 1'b1;
      up_rst = 1'b1;
      step(); step();
      up_rst = 1'b0;
      mon_en = 1;
      chk_reset_vals("reset");

      // seed 0, samples 1 then 0
      arm(32'h0);
      chk("arm_busy", 32'(busy), 32'h1);
      sample(32'h1);
      chk("t1_sig0", sig, 32'h1);
      sample(32'h0);
      chk("t1_sig1", sig, 32'h2);
      chk("t1_cnt", sample_cnt, 32'd2);
      bus_if.in_valid = 1'b0;
      step();
      chk("t1_done", 32'(done), 32'h1);
      chk("t1_busy", 32'(busy), 32'h0);

      // MSB feedback
      arm(32'h8000_0000);
      sample(32'h0);
      chk("t2_sig", sig, 32'h04C1_1DB7);
      chk("t2_ones", ones_cnt, 32'h0);
      bus_if.in_valid = 1'b0;
      step();

      // four all-ones samples, then drain
      bus_if.out_ready = 1'b0;
      arm(32'h0);
      for (int i = 0; i < 4; i++) sample(32'hFFFF_FFFF);
      bus_if.in_valid = 1'b0;
      step();
      chk("t3_ones", ones_cnt, 32'd128);
      bus_if.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t3_pop_valid", 32'(bus_if.out_valid), 32'h1);
         chk("t3_pop_data", bus_if.out_data, 32'hFFFF_FFFF);
         step();
      end
      chk("t3_empty", 32'(bus_if.out_valid), 32'h0);

      // overflow, then full with simultaneous push and pop
      bus_if.out_ready = 1'b0;
      arm($urandom);
      for (int i = 0; i < 20; i++) begin
         data[i] = $urandom;
         sample(data[i]);
      end
      chk("t4_ovf", 32'(overflow), 32'h1);
      chk("t4_cnt", sample_cnt, 32'd20);
      chk("t4_head", bus_if.out_data, data[0]);
      d21 = $urandom;
      bus_if.out_ready = 1'b1;
      sample(d21);
      bus_if.in_valid = 1'b0; bus_if.out_ready = 1'b0;
      chk("t4_ovf_hold", 32'(overflow), 32'h1);
      chk("t4_cnt21", sample_cnt, 32'd21);
      chk("t4_head2", bus_if.out_data, data[1]);
      step();
      bus_if.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("t4_drain", bus_if.out_data, (i < 15) ? data[i+1] : d21);
         step();
      end
      chk("t4_empty", 32'(bus_if.out_valid), 32'h0);

      // arm mid-capture with a coincident sample
      bus_if.out_ready = 1'b0;
      arm($urandom);
      for (int i = 0; i < 5; i++) sample($urandom);
      s2 = $urandom;
      cfg_seed = s2; cfg_arm = 1'b1;
      sample($urandom);
      cfg_arm = 1'b0; bus_if.in_valid = 1'b0;
      chk("t5_sig", sig, s2);
      chk("t5_cnt", sample_cnt, 32'h0);
      chk("t5_ones", ones_cnt, 32'h0);
      chk("t5_ovalid", 32'(bus_if.out_valid), 32'h0);
      chk("t5_busy", 32'(busy), 32'h1);
      chk("t5_done", 32'(done), 32'h0);
      step();
      chk("t5_still_armed", 32'(busy), 32'h1);

      // reset during capture with buffered data
      arm($urandom);
      for (int i = 0; i < 3; i++) sample($urandom);
      up_rst = 1'b1;
      sample($urandom);
      up_rst = 1'b0;
      chk_reset_vals("t6");
      for (int i = 0; i < 5; i++) sample($urandom);
      bus_if.in_valid = 1'b0;
      chk("t6_cnt_after", sample_cnt, 32'h0);
      chk("t6_ovalid_after", 32'(bus_if.out_valid), 32'h0);
      chk("t6_busy_after", 32'(busy), 32'h0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         up_rst           = ($urandom_range(0, 999) < 2);
         cfg_arm          = ($urandom_range(0, 99) < 3);
         cfg_seed         = $urandom;
         bus_if.in_valid  = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 3))
            0:       bus_if.in_data = 32'hFFFF_FFFF;
            1:       bus_if.in_data = 32'h0;
            default: bus_if.in_data = $urandom;
         endcase
         bus_if.out_ready = ($urandom_range(0, 9) < 4);
         step();
      end
      up_rst = 1'b0; cfg_arm = 1'b0; bus_if.in_valid = 1'b0; bus_if.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
